// File: rtl/wb_pkg.sv
// Shared widths, source encoding and request record for the write-back port arbiter.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready holding register. A drain on the same edge as a new
// handshake lets the slot refill without a bubble.
module wb_hold_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              slot_v,
  output logic [ADDR_W-1:0] slot_rd,
  output logic [DATA_W-1:0] slot_data
);

  logic              v_q, v_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    in_ready = rst_n && (!v_q || drain);
    v_d      = v_q;
    rd_d     = rd_q;
    data_d   = data_q;
    if (in_valid && in_ready) begin
      v_d    = 1'b1;
      rd_d   = in_rd;
      data_d = in_data;
    end else if (drain) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign slot_v    = v_q;
  assign slot_rd   = rd_q;
  assign slot_data = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the ALU and load result
// slots round-robin, and exports which registers still have a write in flight.
module wb_port_arbiter #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int NREGS  = wb_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              regWriteControl,
  output logic [ADDR_W-1:0] writeRegAddress,
  output logic [DATA_W-1:0] writeRegData,
  output logic [NREGS-1:0]  pending,
  output logic              last_grant
);
  import wb_pkg::*;

  logic              alu_v, mem_v;
  logic [ADDR_W-1:0] alu_rd_s, mem_rd_s;
  logic [DATA_W-1:0] alu_data_s, mem_data_s;
  logic              grant_alu, grant_mem, any_grant, grant_src;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              prio_q, prio_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_grant_q, last_grant_d;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (alu_valid),
    .in_ready  (alu_ready),
    .in_rd     (alu_rd),
    .in_data   (alu_data),
    .drain     (grant_alu),
    .slot_v    (alu_v),
    .slot_rd   (alu_rd_s),
    .slot_data (alu_data_s)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mem_valid),
    .in_ready  (mem_ready),
    .in_rd     (mem_rd),
    .in_data   (mem_data),
    .drain     (grant_mem),
    .slot_v    (mem_v),
    .slot_rd   (mem_rd_s),
    .slot_data (mem_data_s)
  );

  // The pointer always ends up on the source not just served, which covers
  // both the contended flip and the uncontended hand-over.
  always_comb begin
    grant_alu    = alu_v && (!mem_v || prio_q == SRC_ALU);
    grant_mem    = mem_v && (!alu_v || prio_q == SRC_MEM);
    any_grant    = grant_alu || grant_mem;
    grant_src    = grant_mem ? SRC_MEM : SRC_ALU;
    sel_rd       = grant_mem ? mem_rd_s : alu_rd_s;
    sel_data     = grant_mem ? mem_data_s : alu_data_s;

    prio_d       = prio_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (any_grant) begin
      prio_d       = other_src(grant_src);
      wr_en_d      = (sel_rd != '0);
      wr_addr_d    = sel_rd;
      wr_data_d    = sel_data;
      last_grant_d = grant_src;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q       <= SRC_MEM;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= SRC_ALU;
    end else begin
      prio_q       <= prio_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign regWriteControl = wr_en_q;
  assign writeRegAddress = wr_addr_q;
  assign writeRegData    = wr_data_q;
  assign last_grant      = last_grant_q;

  // r0 is hard-wired, so it never reports a write in flight.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
    if (gi == 0) begin : g_zero
      assign pending[gi] = 1'b0;
    end else begin : g_reg
      assign pending[gi] = (alu_v && alu_rd_s == ADDR_W'(gi)) ||
                           (mem_v && mem_rd_s == ADDR_W'(gi)) ||
                           (wr_en_q && wr_addr_q == ADDR_W'(gi));
    end
  end

endmodule
